// File: rtl/pcie_queue_pkg.sv
// rtl/pcie_queue_pkg.sv - register map, scheduler states and per-queue register record
package pcie_queue_pkg;

  localparam int REG_TAIL    = 0;
  localparam int REG_HEAD    = 1;
  localparam int REG_KMEM_LO = 2;
  localparam int REG_KMEM_HI = 3;
  localparam int REG_CTRL    = 4;

  localparam int CTRL_ENABLE_BIT = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PRESENT
  } sched_state_t;

  // Pointers are held at full dword width with the unused upper bits kept at zero.
  typedef struct packed {
    logic [31:0] head;
    logic [31:0] tail;
    logic [63:0] kmem;
    logic        enable;
  } queue_regs_t;

endpackage

// File: rtl/rr_next_enabled.sv
// rtl/rr_next_enabled.sv - wrap-around search for the first enabled queue after cur_q
module rr_next_enabled #(
  parameter  int NB_QUEUES  = 16,
  localparam int QIDX_WIDTH = $clog2(NB_QUEUES)
) (
  input  logic [NB_QUEUES-1:0]  enable_i,
  input  logic [QIDX_WIDTH-1:0] cur_q_i,
  output logic [QIDX_WIDTH-1:0] next_q_o,
  output logic                  found_o
);

  logic [QIDX_WIDTH-1:0] idx;

  always_comb begin
    next_q_o = cur_q_i;
    found_o  = 1'b0;
    idx      = cur_q_i;
    // Offset NB_QUEUES truncates back to cur_q itself, so the current queue is tried last.
    for (int i = 1; i <= NB_QUEUES; i++) begin
      idx = cur_q_i + QIDX_WIDTH'(i);
      if (!found_o && enable_i[idx]) begin
        next_q_o = idx;
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_queue_regfile.sv
// rtl/pcie_queue_regfile.sv - per-queue PIO register pages and round-robin queue presenter
module pcie_queue_regfile
  import pcie_queue_pkg::*;
#(
  parameter  int NB_QUEUES  = 16,
  parameter  int RB_AWIDTH  = 18,
  parameter  int ADDR_WIDTH = 22,
  localparam int QIDX_WIDTH = $clog2(NB_QUEUES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pio_address,
  input  logic                  pio_write,
  input  logic                  pio_read,
  input  logic [511:0]          pio_writedata,
  input  logic [63:0]           pio_byteenable,
  output logic                  pio_readdatavalid,
  output logic [511:0]          pio_readdata,
  input  logic                  dma_done,
  input  logic [RB_AWIDTH-1:0]  dma_new_tail,
  output logic                  sel_valid,
  output logic [QIDX_WIDTH-1:0] sel_queue,
  output logic [RB_AWIDTH-1:0]  sel_head,
  output logic [RB_AWIDTH-1:0]  sel_tail,
  output logic [63:0]           sel_kmem_addr,
  output logic [RB_AWIDTH-1:0]  sel_free
);

  queue_regs_t           regs_q [NB_QUEUES];
  queue_regs_t           regs_d [NB_QUEUES];
  sched_state_t          state_q, state_d;
  logic [QIDX_WIDTH-1:0] cur_q_q, cur_q_d;
  logic [NB_QUEUES-1:0]  enable_vec;
  logic [QIDX_WIDTH-1:0] rr_next;
  logic                  rr_found;
  logic [QIDX_WIDTH-1:0] pio_q;
  logic                  pio_in_map;
  logic                  dma_commit;
  logic [511:0]          rd_line;
  logic                  rd_v1_q, rd_v2_q;
  logic [511:0]          rd_data1_q, rd_data2_q;
  logic [QIDX_WIDTH-1:0] sel_queue_q;
  logic [RB_AWIDTH-1:0]  sel_head_q, sel_tail_q, sel_free_q;
  logic [63:0]           sel_kmem_q;
  logic [RB_AWIDTH-1:0]  nx_head, nx_tail;
  logic                  unused_pio_bits;

  // NB_QUEUES is a power of two, so every decoded index names a real queue.
  assign pio_q      = pio_address[12 +: QIDX_WIDTH];
  assign pio_in_map = (pio_address[11:6] == 6'd0);
  assign dma_commit = dma_done && (state_q == S_PRESENT);

  assign unused_pio_bits = ^{pio_address[5:0], pio_address[ADDR_WIDTH-1:12+QIDX_WIDTH],
                             pio_writedata[511:129], pio_writedata[63:32+RB_AWIDTH],
                             pio_writedata[31:0], pio_byteenable[63:20], pio_byteenable[3:0]};

  always_comb begin
    regs_d = regs_q;
    if (pio_write && pio_in_map) begin
      if (&pio_byteenable[4*REG_HEAD +: 4])
        regs_d[pio_q].head = 32'(pio_writedata[32*REG_HEAD +: RB_AWIDTH]);
      if (&pio_byteenable[4*REG_KMEM_LO +: 4])
        regs_d[pio_q].kmem[31:0] = pio_writedata[32*REG_KMEM_LO +: 32];
      if (&pio_byteenable[4*REG_KMEM_HI +: 4])
        regs_d[pio_q].kmem[63:32] = pio_writedata[32*REG_KMEM_HI +: 32];
      if (&pio_byteenable[4*REG_CTRL +: 4])
        regs_d[pio_q].enable = pio_writedata[32*REG_CTRL + CTRL_ENABLE_BIT];
    end
    if (dma_commit) regs_d[cur_q_q].tail = 32'(dma_new_tail);
  end

  always_comb begin
    enable_vec = '0;
    for (int i = 0; i < NB_QUEUES; i++) enable_vec[i] = regs_q[i].enable;
  end

  always_comb begin
    rd_line = '0;
    if (pio_in_map) begin
      rd_line[32*REG_TAIL    +: 32]            = regs_q[pio_q].tail;
      rd_line[32*REG_HEAD    +: 32]            = regs_q[pio_q].head;
      rd_line[32*REG_KMEM_LO +: 32]            = regs_q[pio_q].kmem[31:0];
      rd_line[32*REG_KMEM_HI +: 32]            = regs_q[pio_q].kmem[63:32];
      rd_line[32*REG_CTRL + CTRL_ENABLE_BIT]   = regs_q[pio_q].enable;
    end
  end

  rr_next_enabled #(.NB_QUEUES(NB_QUEUES)) u_rr (
    .enable_i (enable_vec),
    .cur_q_i  (cur_q_q),
    .next_q_o (rr_next),
    .found_o  (rr_found)
  );

  always_comb begin
    state_d = state_q;
    cur_q_d = cur_q_q;
    case (state_q)
      S_IDLE:    if (|enable_vec) state_d = S_LOAD;
      S_LOAD: begin
        if (rr_found) begin
          cur_q_d = rr_next;
          state_d = S_PRESENT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRESENT: if (dma_done || !enable_vec[cur_q_q]) state_d = S_LOAD;
      default:   state_d = S_IDLE;
    endcase
  end

  // Indexed by the next cur_q so a newly loaded queue appears with its own pointers.
  assign nx_head = regs_q[cur_q_d].head[RB_AWIDTH-1:0];
  assign nx_tail = regs_q[cur_q_d].tail[RB_AWIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_q_q     <= QIDX_WIDTH'(NB_QUEUES - 1);
      for (int i = 0; i < NB_QUEUES; i++) regs_q[i] <= '0;
      rd_v1_q     <= 1'b0;
      rd_v2_q     <= 1'b0;
      rd_data1_q  <= '0;
      rd_data2_q  <= '0;
      sel_queue_q <= '0;
      sel_head_q  <= '0;
      sel_tail_q  <= '0;
      sel_free_q  <= '0;
      sel_kmem_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_q_q     <= cur_q_d;
      regs_q      <= regs_d;
      rd_v1_q     <= pio_read;
      rd_data1_q  <= rd_line;
      rd_v2_q     <= rd_v1_q;
      rd_data2_q  <= rd_data1_q;
      sel_queue_q <= cur_q_d;
      sel_head_q  <= nx_head;
      sel_tail_q  <= nx_tail;
      sel_free_q  <= nx_head - nx_tail - RB_AWIDTH'(1);
      sel_kmem_q  <= regs_q[cur_q_d].kmem;
    end
  end

  assign pio_readdatavalid = rd_v2_q;
  assign pio_readdata      = rd_data2_q;
  assign sel_valid         = (state_q == S_PRESENT);
  assign sel_queue         = sel_queue_q;
  assign sel_head          = sel_head_q;
  assign sel_tail          = sel_tail_q;
  assign sel_free          = sel_free_q;
  assign sel_kmem_addr     = sel_kmem_q;

endmodule

// File: tb/tb_pcie_queue_regfile.sv
// tb/tb_pcie_queue_regfile.sv - vector table, directed scheduler sequences and randomized PIO scoreboard
module tb_pcie_queue_regfile;

  localparam int NBQ = 16;
  localparam int RBW = 18;
  localparam int AW  = 22;
  localparam int QW  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [AW-1:0]  pio_address;
  logic           pio_write, pio_read;
  logic [511:0]   pio_writedata;
  logic [63:0]    pio_byteenable;
  logic           pio_readdatavalid;
  logic [511:0]   pio_readdata;
  logic           dma_done;
  logic [RBW-1:0] dma_new_tail;
  logic           sel_valid;
  logic [QW-1:0]  sel_queue;
  logic [RBW-1:0] sel_head, sel_tail, sel_free;
  logic [63:0]    sel_kmem_addr;

  always #5 clk = ~clk;

  pcie_queue_regfile #(.NB_QUEUES(NBQ), .RB_AWIDTH(RBW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .pio_address(pio_address), .pio_write(pio_write), .pio_read(pio_read),
    .pio_writedata(pio_writedata), .pio_byteenable(pio_byteenable),
    .pio_readdatavalid(pio_readdatavalid), .pio_readdata(pio_readdata),
    .dma_done(dma_done), .dma_new_tail(dma_new_tail), .sel_valid(sel_valid), .sel_queue(sel_queue),
    .sel_head(sel_head), .sel_tail(sel_tail), .sel_kmem_addr(sel_kmem_addr), .sel_free(sel_free)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [RBW-1:0] m_head [NBQ];
  logic [RBW-1:0] m_tail [NBQ];
  logic [63:0]    m_kmem [NBQ];
  logic           m_en   [NBQ];

  typedef struct {
    logic [AW-1:0] addr;
    logic [19:0]   be;
    logic [159:0]  wdata;
    logic [159:0]  exp;
  } vec_t;
  vec_t vt [7];

  typedef struct {
    int           due;
    logic [511:0] d;
  } resp_t;
  resp_t sb [$];
  int    cyc;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] model_line(input logic [AW-1:0] a);
    logic [QW-1:0] q;
    q = a[12 +: QW];
    if (a[11:6] != 6'd0) return '0;
    return {352'h0, 31'h0, m_en[q], m_kmem[q][63:32], m_kmem[q][31:0],
            14'h0, m_head[q], 14'h0, m_tail[q]};
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [63:0] be, input logic [511:0] wd);
    logic [QW-1:0] q;
    q = a[12 +: QW];
    if (a[11:6] == 6'd0) begin
      if (be[7:4]   == 4'hF) m_head[q]        = wd[32 +: RBW];
      if (be[11:8]  == 4'hF) m_kmem[q][31:0]  = wd[64 +: 32];
      if (be[15:12] == 4'hF) m_kmem[q][63:32] = wd[96 +: 32];
      if (be[19:16] == 4'hF) m_en[q]          = wd[128];
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NBQ; i++) begin
      m_head[i] = '0; m_tail[i] = '0; m_kmem[i] = '0; m_en[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    clear_model();
    rst = 1'b0;
  endtask

  task automatic pio_wr(input logic [AW-1:0] a, input logic [19:0] be, input logic [159:0] dws);
    pio_address    = a;
    pio_write      = 1'b1;
    pio_writedata  = {352'h0, dws};
    pio_byteenable = {44'h0, be};
    model_write(a, pio_byteenable, pio_writedata);
    step();
    pio_write = 1'b0;
  endtask

  task automatic wr_ctrl(input logic [QW-1:0] q, input logic en);
    pio_wr({6'h0, q, 12'h0}, 20'hF0000, {31'h0, en, 128'h0});
  endtask

  task automatic do_read(input string name, input logic [AW-1:0] a, input logic [511:0] exp);
    pio_address = a;
    pio_read    = 1'b1;
    step();
    pio_read = 1'b0;
    check({name, "_early"}, 512'(pio_readdatavalid), 512'(0));
    step();
    check({name, "_valid"}, 512'(pio_readdatavalid), 512'(1));
    check({name, "_data"}, pio_readdata, exp);
  endtask

  task automatic dma_pulse(input logic [QW-1:0] q, input logic [RBW-1:0] nt, input bit upd);
    dma_done     = 1'b1;
    dma_new_tail = nt;
    if (upd) m_tail[q] = nt;
    step();
    dma_done = 1'b0;
  endtask

  task automatic wait_sel(input string name);
    int n;
    n = 0;
    while (!sel_valid && n < 40) begin
      step();
      n++;
    end
    n_total++;
    if (sel_valid) n_pass++;
    else $display("FAIL %s: sel_valid got 0 expected 1 within 40 cycles", name);
  endtask

  task automatic sb_step();
    step();
    cyc++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      check("rand_rvalid", 512'(pio_readdatavalid), 512'(1));
      check("rand_rdata", pio_readdata, sb[0].d);
      void'(sb.pop_front());
    end else begin
      check("rand_rvalid_idle", 512'(pio_readdatavalid), 512'(0));
    end
  endtask

  initial begin
    logic [AW-1:0]  a;
    logic [63:0]    be;
    logic [511:0]   wd, exp_line;
    logic [RBW-1:0] nt;
    int             seq [4];

    seq = '{0, 5, 9, 0};
    vt[0] = '{22'h002000, 20'hFFFF0, {32'h1, 32'h1, 32'h23456780, 32'h100, 32'h0},
              {32'h1, 32'h1, 32'h23456780, 32'h100, 32'h0}};
    vt[1] = '{22'h002000, 20'hFFF7F, {32'h1, 32'h2, 32'hAAAA0000, 32'h200, 32'h55},
              {32'h1, 32'h2, 32'hAAAA0000, 32'h100, 32'h0}};
    vt[2] = '{22'h007000, 20'hFFFF0, {32'hFFFFFFFE, 32'h22222222, 32'h11111111, 32'hFFFFFFFF, 32'h0},
              {32'h0, 32'h22222222, 32'h11111111, 32'h0003FFFF, 32'h0}};
    vt[3] = '{22'h007040, 20'hFFFFF, {32'h1, 32'h9, 32'h9, 32'h5, 32'h7}, 160'h0};
    vt[4] = '{22'h007000, 20'h0F000, {32'hFFFFFFFF, 32'h33333333, 32'h44444444, 32'h55555555, 32'h0},
              {32'h0, 32'h33333333, 32'h11111111, 32'h0003FFFF, 32'h0}};
    vt[5] = '{22'h00F000, 20'hF0000, {32'h80000001, 32'h1, 32'h1, 32'h1, 32'h0},
              {32'h1, 32'h0, 32'h0, 32'h0, 32'h0}};
    vt[6] = '{22'h007000, 20'h000F0, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0},
              {32'h0, 32'h33333333, 32'h11111111, 32'h0001BEEF, 32'h0}};

    rst = 1'b1; pio_address = '0; pio_write = 1'b0; pio_read = 1'b0;
    pio_writedata = '0; pio_byteenable = '0; dma_done = 1'b0; dma_new_tail = '0;
    cyc = 0;
    clear_model();
    step();
    step();
    check("rst_sel_valid", 512'(sel_valid), 512'(0));
    check("rst_rvalid", 512'(pio_readdatavalid), 512'(0));
    check("rst_sel_queue", 512'(sel_queue), 512'(0));
    check("rst_sel_free", 512'(sel_free), 512'(0));
    rst = 1'b0;

    do_read("rd_empty_q3", 22'h003000, 512'h0);
    check("idle_sel_valid", 512'(sel_valid), 512'(0));

    for (int i = 0; i < 7; i++) begin
      pio_wr(vt[i].addr, vt[i].be, vt[i].wdata);
      do_read($sformatf("vec%0d", i), vt[i].addr, {352'h0, vt[i].exp});
    end

    step();
    check("q2_sel_valid", 512'(sel_valid), 512'(1));
    check("q2_sel_queue", 512'(sel_queue), 512'(2));
    check("q2_sel_head", 512'(sel_head), 512'(18'h100));
    check("q2_sel_tail", 512'(sel_tail), 512'(0));
    check("q2_sel_free", 512'(sel_free), 512'(18'hFF));
    check("q2_sel_kmem", 512'(sel_kmem_addr), 512'(64'h2_AAAA_0000));

    pio_wr(22'h002000, 20'h000F0, {96'h0, 32'h180, 32'h0});
    check("head_lat_t1", 512'(sel_head), 512'(18'h100));
    step();
    check("head_lat_t2", 512'(sel_head), 512'(18'h180));
    check("free_lat_t2", 512'(sel_free), 512'(18'h17F));

    do_reset();
    wr_ctrl(4'd0, 1'b1);
    wr_ctrl(4'd5, 1'b1);
    wr_ctrl(4'd9, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_sel("sched_wait");
      check($sformatf("sched_q%0d", i), 512'(sel_queue), 512'(seq[i]));
      nt = RBW'($urandom);
      dma_pulse(4'(seq[i]), nt, 1'b1);
      check("sched_gap", 512'(sel_valid), 512'(0));
      step();
      check("sched_next", 512'(sel_valid), 512'(1));
    end
    check("sched_q_after", 512'(sel_queue), 512'(5));
    do_read("tail_q0", 22'h000000, model_line(22'h000000));
    do_read("tail_q5", 22'h005000, model_line(22'h005000));
    do_read("tail_q9", 22'h009000, model_line(22'h009000));

    wr_ctrl(4'd5, 1'b0);
    check("dis5_t1", 512'(sel_valid), 512'(1));
    step();
    check("dis5_load", 512'(sel_valid), 512'(0));
    step();
    check("dis5_next_valid", 512'(sel_valid), 512'(1));
    check("dis5_next_q", 512'(sel_queue), 512'(9));

    wr_ctrl(4'd0, 1'b0);
    wr_ctrl(4'd9, 1'b0);
    step();
    step();
    check("all_off_idle", 512'(sel_valid), 512'(0));
    dma_pulse(4'd0, 18'h1234, 1'b0);
    step();
    do_read("idle_dma_q0", 22'h000000, model_line(22'h000000));
    do_read("idle_dma_q9", 22'h009000, model_line(22'h009000));

    wr_ctrl(4'd3, 1'b1);
    wait_sel("q3_wait");
    check("q3_sel", 512'(sel_queue), 512'(3));
    exp_line = model_line(22'h003000);
    pio_address = 22'h003000; pio_read = 1'b1; pio_write = 1'b1;
    pio_byteenable = {44'h0, 20'hF0000}; pio_writedata = '0;
    model_write(pio_address, pio_byteenable, pio_writedata);
    dma_done = 1'b1; dma_new_tail = 18'h00222; m_tail[3] = 18'h00222;
    step();
    pio_read = 1'b0; pio_write = 1'b0; dma_done = 1'b0;
    check("coinc_early", 512'(pio_readdatavalid), 512'(0));
    step();
    check("coinc_valid", 512'(pio_readdatavalid), 512'(1));
    check("coinc_old_tail", pio_readdata, exp_line);
    check("coinc_idle", 512'(sel_valid), 512'(0));
    do_read("coinc_after", 22'h003000, model_line(22'h003000));

    pio_wr(22'h000000, 20'hF00F0, {32'h1, 64'h0, 32'h10, 32'h0});
    wait_sel("wrap_wait");
    check("wrap_q", 512'(sel_queue), 512'(0));
    dma_pulse(4'd0, 18'h3FFFF, 1'b1);
    check("wrap_gap", 512'(sel_valid), 512'(0));
    step();
    check("wrap_valid", 512'(sel_valid), 512'(1));
    check("wrap_tail", 512'(sel_tail), 512'(18'h3FFFF));
    check("wrap_free", 512'(sel_free), 512'(18'h10));
    pio_wr(22'h000000, 20'h000F0, {96'h0, 32'h3FFFF, 32'h0});
    check("eq_free_t1", 512'(sel_free), 512'(18'h10));
    step();
    check("eq_free_t2", 512'(sel_free), 512'(18'h3FFFF));

    pio_address = 22'h000000; pio_read = 1'b1;
    step();
    pio_read = 1'b0; rst = 1'b1;
    step();
    check("rst_midread_1", 512'(pio_readdatavalid), 512'(0));
    step();
    check("rst_midread_2", 512'(pio_readdatavalid), 512'(0));
    rst = 1'b0;
    clear_model();

    for (int c = 0; c < 600; c++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 3) != 0) a[11:6] = 6'd0;
      for (int k = 0; k < 16; k++) begin
        be[4*k +: 4] = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
        wd[32*k +: 32] = $urandom;
      end
      pio_address = a; pio_byteenable = be; pio_writedata = wd;
      pio_read  = ($urandom_range(0, 2) != 0);
      pio_write = ($urandom_range(0, 1) != 0);
      if (pio_read) sb.push_back('{cyc + 2, model_line(a)});
      if (pio_write) model_write(a, be, wd);
      sb_step();
    end
    pio_read = 1'b0; pio_write = 1'b0;
    sb_step();
    sb_step();
    check("rand_drained", 512'(sb.size()), 512'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
